// File: rtl/sns_ctrl_pkg.sv
// Shared definitions for the shift-and-save history buffer controller.
// The state encoding and default sizes are common to the front-end and the buffer.
package sns_ctrl_pkg;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } sns_state_e;

  localparam int SNS_DEPTH      = 10;
  localparam int SNS_DATA_WIDTH = 32;

endpackage

// File: rtl/sns_rr_arbiter.sv
// Combinational round-robin pick: first candidate searching upward from ptr+1, wrapping.
module sns_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int GW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] cand,
  input  logic [GW-1:0]      ptr,
  output logic               grant_valid,
  output logic [GW-1:0]      grant_idx
);

  // Scan from farthest to nearest so the nearest candidate after ptr wins.
  always_comb begin
    grant_idx = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      if (cand[GW'((int'(ptr) + i) % NUM_REQ)]) begin
        grant_idx = GW'((int'(ptr) + i) % NUM_REQ);
      end
    end
  end

  assign grant_valid = |cand;

endmodule

// File: rtl/sns_push_arbiter.sv
// Push front-end for the history buffer: round-robin grants, zero-fill flush,
// occupancy and sticky overflow tracking. All outputs are registered.
//
// state    | meaning
// ST_RUN   | arbitrate requesters, at most one push per cycle
// ST_FLUSH | push zeros until DEPTH shifts have been issued
module sns_push_arbiter
  import sns_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = SNS_DATA_WIDTH,
  parameter int NUM_REQ    = 4,
  parameter int DEPTH      = SNS_DEPTH,
  localparam int GW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CW        = $clog2(DEPTH + 1)
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            ack,
  input  logic                          freeze,
  input  logic                          flush_req,
  output logic                          shift_en,
  output logic [DATA_WIDTH-1:0]         new_value,
  output logic [GW-1:0]                 grant_id,
  output logic                          busy,
  output logic [CW-1:0]                 valid_count,
  output logic                          overflow
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  sns_state_e              state, state_n;
  logic [NUM_REQ-1:0]      ack_n;
  logic                    shift_n, busy_n, ovf_n;
  logic [DATA_WIDTH-1:0]   newv_n;
  logic [GW-1:0]           gid_n, ptr, ptr_n;
  logic [CW-1:0]           vc_n, cnt, cnt_n;
  logic [DATA_WIDTH-1:0]   data_arr [NUM_REQ];
  logic [NUM_REQ-1:0]      cand;
  logic                    grant_valid;
  logic [GW-1:0]           grant_idx;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign data_arr[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // A source acked this cycle is masked so its still-high req is not granted twice.
  assign cand = req & ~ack;

  sns_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .GW      (GW)
  ) u_rr (
    .cand        (cand),
    .ptr         (ptr),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  always_comb begin
    state_n = state;
    ack_n   = '0;
    shift_n = 1'b0;
    busy_n  = busy;
    ovf_n   = overflow;
    newv_n  = new_value;
    gid_n   = grant_id;
    ptr_n   = ptr;
    vc_n    = valid_count;
    cnt_n   = cnt;
    case (state)
      ST_RUN: begin
        if (flush_req) begin
          state_n = ST_FLUSH;
          shift_n = 1'b1;
          newv_n  = '0;
          busy_n  = 1'b1;
          cnt_n   = CW'(DEPTH - 1);
          vc_n    = '0;
          ovf_n   = 1'b0;
        end else if (!freeze && grant_valid) begin
          ack_n[grant_idx] = 1'b1;
          shift_n = 1'b1;
          newv_n  = data_arr[grant_idx];
          gid_n   = grant_idx;
          ptr_n   = grant_idx;
          if (valid_count == DEPTH_C) begin
            ovf_n = 1'b1;
          end else begin
            vc_n = valid_count + CW'(1);
          end
        end
      end
      ST_FLUSH: begin
        // cnt holds the zero pushes still owed after the current one.
        if (cnt == '0) begin
          state_n = ST_RUN;
          busy_n  = 1'b0;
        end else begin
          cnt_n   = cnt - CW'(1);
          shift_n = 1'b1;
          newv_n  = '0;
        end
      end
      default: state_n = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= ST_RUN;
      ack         <= '0;
      shift_en    <= 1'b0;
      busy        <= 1'b0;
      overflow    <= 1'b0;
      new_value   <= '0;
      grant_id    <= '0;
      valid_count <= '0;
      ptr         <= GW'(NUM_REQ - 1);
      cnt         <= '0;
    end else begin
      state       <= state_n;
      ack         <= ack_n;
      shift_en    <= shift_n;
      busy        <= busy_n;
      overflow    <= ovf_n;
      new_value   <= newv_n;
      grant_id    <= gid_n;
      valid_count <= vc_n;
      ptr         <= ptr_n;
      cnt         <= cnt_n;
    end
  end

endmodule
